// File: rtl/divfloat_sched.sv
// Round-robin front end that lets NREQ requesters share one pipelined float divider.
// A tag pipeline running in lockstep with the divider routes each quotient back to its owner.
module divfloat_sched #(
   parameter int NREQ = 4,
   parameter int LAT  = 28
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ce,
   input  logic               flush,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*32-1:0] req_a,
   input  logic [NREQ*32-1:0] req_b,
   output logic [NREQ-1:0]    req_ready,
   output logic [NREQ-1:0]    rsp_valid,
   output logic [31:0]        rsp_data,
   output logic [31:0]        div_a,
   output logic [31:0]        div_b,
   output logic               div_ce,
   input  logic [31:0]        div_result,
   output logic               busy
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [IW-1:0]  ptr_q;
   logic [LAT-1:0] tag_valid_q;
   logic [IW-1:0]  tag_owner_q [LAT];
   logic           grant_any;
   logic [IW-1:0]  grant_idx;

   // Search starts one past the last grant; one subtraction wraps because ptr+s < 2*NREQ.
   always_comb begin
      logic [IW:0] cand;
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      if (rst_n && ce && !flush) begin
         for (int s = 1; s <= NREQ; s++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(s);
            if (cand >= (IW+1)'(NREQ)) begin
               cand = cand - (IW+1)'(NREQ);
            end
            if (!grant_any && req_valid[cand[IW-1:0]]) begin
               grant_any = 1'b1;
               grant_idx = cand[IW-1:0];
            end
         end
      end
   end

   always_comb begin
      req_ready = '0;
      div_a     = '0;
      div_b     = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_any && grant_idx == IW'(i)) begin
            req_ready[i] = 1'b1;
            div_a        = req_a[i*32 +: 32];
            div_b        = req_b[i*32 +: 32];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= IW'(NREQ-1);
      end else if (grant_any) begin
         ptr_q <= grant_idx;
      end
   end

   // Flush blocks the grant, so clearing everything also leaves stage 0 empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_valid_q <= '0;
      end else if (ce) begin
         if (flush) begin
            tag_valid_q <= '0;
         end else begin
            for (int i = LAT-1; i > 0; i--) begin
               tag_valid_q[i] <= tag_valid_q[i-1];
            end
            tag_valid_q[0] <= grant_any;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LAT; i++) begin
            tag_owner_q[i] <= '0;
         end
      end else if (ce) begin
         for (int i = LAT-1; i > 0; i--) begin
            tag_owner_q[i] <= tag_owner_q[i-1];
         end
         tag_owner_q[0] <= grant_idx;
      end
   end

   always_comb begin
      rsp_valid = '0;
      for (int i = 0; i < NREQ; i++) begin
         rsp_valid[i] = ce && tag_valid_q[LAT-1] && (tag_owner_q[LAT-1] == IW'(i));
      end
   end

   assign rsp_data = div_result;
   assign div_ce   = ce;
   assign busy     = |tag_valid_q;

endmodule
